// File: rtl/display_pkg.sv
// Shared types and defaults for the multiplexed 7-segment scan path.
package display_pkg;

  localparam int DIGIT_W          = 4;
  localparam int DEF_N_DIGITS     = 4;
  localparam int DEF_REFRESH_DIV  = 1000;
  localparam int DEF_GUARD_CYCLES = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GUARD = 2'd2
  } scan_state_t;

endpackage

// File: rtl/scan_tick_gen.sv
// Divide counter for the scan FSM: flags the last drive cycle and the last guard cycle.
module scan_tick_gen #(
  parameter int REFRESH_DIV  = 1000,
  parameter int GUARD_CYCLES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic slot_end,
  output logic guard_end
);

  // Wide enough for whichever of the two intervals is longer.
  localparam int CNT_MAX = (REFRESH_DIV > GUARD_CYCLES) ? REFRESH_DIV : GUARD_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign slot_end  = (cnt == CNT_W'(REFRESH_DIV - 1));
  assign guard_end = (cnt == CNT_W'(GUARD_CYCLES - 1));

endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed digit scan controller with shadow/display double buffering.
// Optional leading-zero suppression is enabled by defining LEADING_ZERO_BLANK_EN.
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int N_DIGITS     = DEF_N_DIGITS,
  parameter int REFRESH_DIV  = DEF_REFRESH_DIV,
  parameter int GUARD_CYCLES = DEF_GUARD_CYCLES
) (
  input  logic                        iClk,
  input  logic                        iRst,
  input  logic                        iEn,
  input  logic                        iLoad,
  input  logic [DIGIT_W*N_DIGITS-1:0] iData,
  output logic [DIGIT_W-1:0]          oDigit,
  output logic [N_DIGITS-1:0]         oSel,
  output logic                        oBlank,
  output logic                        oFrame,
  output scan_state_t                 oDbgState,
  output logic                        oDbgPending
);

  localparam int                IDX_W   = $clog2(N_DIGITS);
  localparam int                DATA_W  = DIGIT_W * N_DIGITS;
  localparam logic [N_DIGITS-1:0] SEL_ONE = N_DIGITS'(1);

  scan_state_t       state, state_nxt;
  logic [IDX_W-1:0]  idx, idx_nxt;
  logic [DATA_W-1:0] shadow, shadow_nxt;
  logic [DATA_W-1:0] display, display_nxt;
  logic              pending, pending_nxt;
  logic              transfer, wrap, cnt_clr;
  logic              slot_end, guard_end;
  logic              suppress;
  logic [DIGIT_W-1:0]  digit_code;
  logic [N_DIGITS-1:0] sel_nxt;

  scan_tick_gen #(
    .REFRESH_DIV  (REFRESH_DIV),
    .GUARD_CYCLES (GUARD_CYCLES)
  ) u_tick (
    .clk       (iClk),
    .rst       (iRst),
    .clr       (cnt_clr),
    .slot_end  (slot_end),
    .guard_end (guard_end)
  );

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    transfer  = 1'b0;
    wrap      = 1'b0;
    if (!iEn) begin
      state_nxt = IDLE;
      idx_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          state_nxt = DRIVE;
          idx_nxt   = '0;
          transfer  = 1'b1;
        end
        DRIVE: begin
          if (slot_end) state_nxt = GUARD;
        end
        GUARD: begin
          if (guard_end) begin
            state_nxt = DRIVE;
            if (idx == IDX_W'(N_DIGITS - 1)) begin
              idx_nxt  = '0;
              wrap     = 1'b1;
              transfer = 1'b1;
            end else begin
              idx_nxt = idx + IDX_W'(1);
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end

    // Counter restarts on every state change and is parked at zero while idle.
    cnt_clr = (state_nxt != state) || (state_nxt == IDLE);

    // A load landing on a transfer edge bypasses the shadow so the newest data wins.
    shadow_nxt  = shadow;
    display_nxt = display;
    pending_nxt = pending;
    if (transfer && iLoad) begin
      display_nxt = iData;
      shadow_nxt  = iData;
      pending_nxt = 1'b0;
    end else if (transfer && pending) begin
      display_nxt = shadow;
      pending_nxt = 1'b0;
    end else if (iLoad) begin
      shadow_nxt  = iData;
      pending_nxt = 1'b1;
    end

    digit_code = display_nxt[idx_nxt*DIGIT_W +: DIGIT_W];
`ifdef LEADING_ZERO_BLANK_EN
    // Digit k is a leading zero when digits k..N-1 are all zero.
    suppress = (idx_nxt != '0) && ((display_nxt >> (idx_nxt*DIGIT_W)) == '0);
`else
    suppress = 1'b0;
`endif
    sel_nxt = ((state_nxt == DRIVE) && !suppress) ? (SEL_ONE << idx_nxt) : '0;
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state   <= IDLE;
      idx     <= '0;
      shadow  <= '0;
      display <= '0;
      pending <= 1'b0;
      oSel    <= '0;
      oDigit  <= '0;
      oBlank  <= 1'b1;
      oFrame  <= 1'b0;
    end else begin
      state   <= state_nxt;
      idx     <= idx_nxt;
      shadow  <= shadow_nxt;
      display <= display_nxt;
      pending <= pending_nxt;
      oSel    <= sel_nxt;
      oBlank  <= ~|sel_nxt;
      oFrame  <= wrap;
      if (state_nxt == DRIVE) oDigit <= digit_code;
    end
  end

  assign oDbgState   = state;
  assign oDbgPending = pending;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl with N_DIGITS=4, REFRESH_DIV=4, GUARD_CYCLES=1.
`timescale 1ns/1ps
module tb_display_scan_ctrl;
  import display_pkg::*;

  localparam int N = 4;
  localparam int R = 4;
  localparam int G = 1;
  localparam int W = 10;

  logic        clk  = 1'b0;
  logic        rst  = 1'b0;
  logic        en   = 1'b0;
  logic        load = 1'b0;
  logic [15:0] data = 16'h0;
  logic [3:0]  digit;
  logic [3:0]  sel;
  logic        blank;
  logic        frame;
  scan_state_t dbg_state;
  logic        dbg_pending;

  display_scan_ctrl #(
    .N_DIGITS     (N),
    .REFRESH_DIV  (R),
    .GUARD_CYCLES (G)
  ) dut (
    .iClk        (clk),
    .iRst        (rst),
    .iEn         (en),
    .iLoad       (load),
    .iData       (data),
    .oDigit      (digit),
    .oSel        (sel),
    .oBlank      (blank),
    .oFrame      (frame),
    .oDbgState   (dbg_state),
    .oDbgPending (dbg_pending)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- vector table ----------------
  typedef struct {
    logic        en;
    logic        load;
    logic [15:0] data;
    logic [3:0]  sel;
    logic [3:0]  digit;
    logic        blank;
    logic        frame;
  } vec_t;

  vec_t        vecs [0:127];
  int          n_vecs = 0;
  logic [W-1:0] exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  // ---------------- driver / checker tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add_vec(input logic e, input logic l, input logic [15:0] d,
                         input logic [3:0] s, input logic [3:0] dg,
                         input logic b, input logic f);
    vecs[n_vecs].en    = e;
    vecs[n_vecs].load  = l;
    vecs[n_vecs].data  = d;
    vecs[n_vecs].sel   = s;
    vecs[n_vecs].digit = dg;
    vecs[n_vecs].blank = b;
    vecs[n_vecs].frame = f;
    n_vecs++;
  endtask

  // One 20-cycle frame showing disp; first vector is the edge into digit 0.
  task automatic add_frame(input logic [15:0] disp, input logic first_pulse);
    for (int c = 0; c < 20; c++) begin
      int slot;
      logic [3:0] dg;
      slot = c / 5;
      dg   = disp[slot*4 +: 4];
      if ((c % 5) < 4) add_vec(1'b1, 1'b0, 16'h0, 4'(1 << slot), dg, 1'b0, (c == 0) && first_pulse);
      else             add_vec(1'b1, 1'b0, 16'h0, 4'b0000, dg, 1'b1, 1'b0);
    end
  endtask

  function automatic logic [W-1:0] exp_word(input logic [3:0] s, input logic [3:0] dg,
                                            input logic b, input logic f);
    return {s, dg, b, f};
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int base;
    logic lzb;
`ifdef LEADING_ZERO_BLANK_EN
    lzb = 1'b1;
`else
    lzb = 1'b0;
`endif

    // Table: 20 idle cycles, a load while idle, then three frames.
    for (int i = 0; i < 20; i++) add_vec(1'b0, 1'b0, 16'h0, 4'b0000, 4'h0, 1'b1, 1'b0);
    add_vec(1'b0, 1'b1, 16'h4321, 4'b0000, 4'h0, 1'b1, 1'b0);
    add_frame(16'h4321, 1'b0);
    base = n_vecs;
    add_frame(16'h4321, 1'b1);
    vecs[base + 6].load = 1'b1;   // mid-frame load during digit 1
    vecs[base + 6].data = 16'h8765;
    base = n_vecs;
    add_frame(16'h8765, 1'b1);
    vecs[base + 10].load = 1'b1;  // leaves a pending shadow for the coincident-load case
    vecs[base + 10].data = 16'h1111;

    // Reset, including iEn high while reset is held.
    #2 rst = 1'b1;
    step();
    check("rst_sel",   sel, 4'b0000);
    check("rst_blank", blank, 1'b1);
    check("rst_frame", frame, 1'b0);
    check("rst_digit", digit, 4'h0);
    check("rst_pend",  dbg_pending, 1'b0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    en = 1'b1;
    step();
    check("rst_en_sel", sel, 4'b0000);
    en  = 1'b0;
    rst = 1'b0;

    for (int i = 0; i < n_vecs; i++) begin
      en   = vecs[i].en;
      load = vecs[i].load;
      data = vecs[i].data;
      step();
      check($sformatf("tbl%0d_sel", i),   sel,   vecs[i].sel);
      check($sformatf("tbl%0d_digit", i), digit, vecs[i].digit);
      check($sformatf("tbl%0d_blank", i), blank, vecs[i].blank);
      check($sformatf("tbl%0d_frame", i), frame, vecs[i].frame);
    end
    load = 1'b0;

    // Coincident load on the wrap edge: AAAA wins over pending 1111.
    load = 1'b1;
    data = 16'hAAAA;
    step();
    load = 1'b0;
    check("coin_sel",   sel, 4'b0001);
    check("coin_digit", digit, 4'hA);
    check("coin_frame", frame, 1'b1);
    check("coin_pend",  dbg_pending, 1'b0);
    for (int c = 1; c <= 5; c++) step();
    check("coin_d1_sel",   sel, 4'b0010);
    check("coin_d1_digit", digit, 4'hA);

    // Enable drop during digit 2, then restart.
    for (int c = 6; c <= 10; c++) step();
    check("drop_pre_sel", sel, 4'b0100);
    en = 1'b0;
    step();
    check("drop_sel",   sel, 4'b0000);
    check("drop_blank", blank, 1'b1);
    check("drop_frame", frame, 1'b0);
    check("drop_state", 32'(dbg_state), 32'(IDLE));
    for (int c = 0; c < 3; c++) begin
      step();
      check("idle_sel",   sel, 4'b0000);
      check("idle_frame", frame, 1'b0);
    end
    en = 1'b1;
    step();
    check("restart_sel",   sel, 4'b0001);
    check("restart_digit", digit, 4'hA);
    check("restart_frame", frame, 1'b0);

    // Load 0050 mid-frame; it becomes visible at the next wrap.
    for (int c = 1; c <= 19; c++) begin
      load = (c == 1);
      data = 16'h0050;
      step();
      check("restart_no_frame", frame, 1'b0);
      if (c == 1) check("lz_pend", dbg_pending, 1'b1);
    end
    load = 1'b0;

    for (int c = 0; c <= 20; c++) begin
      int slot;
      logic [3:0] dg;
      logic [3:0] s;
      logic [15:0] disp;
      disp = 16'h0050;
      slot = (c % 20) / 5;
      dg   = disp[slot*4 +: 4];
      s    = ((c % 5) < 4 && !(lzb && slot >= 2)) ? 4'(1 << slot) : 4'b0000;
      exp_q.push_back(exp_word(s, dg, (s == 4'b0000), (c % 20) == 0));
    end
    for (int c = 0; c <= 20; c++) begin
      logic [W-1:0] exp_w;
      step();
      exp_w = exp_q.pop_front();
      check($sformatf("lz%0d", c), {sel, digit, blank, frame}, exp_w);
    end

    // Asynchronous reset mid-scan blanks without a clock edge.
    step();
    #2 rst = 1'b1;
    #1;
    check("arst_sel",   sel, 4'b0000);
    check("arst_blank", blank, 1'b1);
    check("arst_state", 32'(dbg_state), 32'(IDLE));
    step();
    rst = 1'b0;
    step();
    check("arst_restart_sel",   sel, 4'b0001);
    check("arst_restart_digit", digit, 4'h0);
    check("arst_restart_frame", frame, 1'b0);

    // ---------------- report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
